// File: rtl/cla_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-lookahead adder among NREQ requesters,
// with a chain lock that forwards Cout as the next beat's carry-in for multi-word sums.

module cla_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p, gen, c;
  logic [4:0]  gc;
  logic        gp, gg;

  // Two-level lookahead: 4-bit group generate/propagate, ripple inside each group.
  always_comb begin
    p   = a ^ b;
    gen = a & b;
    c   = '0;
    gc  = '0;
    gp  = 1'b0;
    gg  = 1'b0;
    gc[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      gp = &p[4*i +: 4];
      gg = gen[4*i+3] | (p[4*i+3] & gen[4*i+2]) | ((&p[4*i+2 +: 2]) & gen[4*i+1])
         | ((&p[4*i+1 +: 3]) & gen[4*i]);
      gc[i+1] = gg | (gp & gc[i]);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      c[4*i] = gc[i];
      for (int unsigned j = 1; j < 4; j++)
        c[4*i+j] = gen[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end
endmodule

module cla_share_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_chain,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);
  if (WIDTH != 16) begin : g_width_check
    $error("cla_share_arbiter: WIDTH must be 16");
  end

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr, owner, g, cand, nxt_ptr;
  logic             carry_q, found, can_issue, hs;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;

  always_comb begin
    found = 1'b0;
    g     = '0;
    cand  = '0;
    if (state == LOCKED) begin
      found = req_valid[owner];
      g     = owner;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = IDW'((32'(ptr) + k) % NREQ);
        if (!found && req_valid[cand]) begin
          found = 1'b1;
          g     = cand;
        end
      end
    end
  end

  assign can_issue = !rsp_valid || rsp_ready;
  assign hs        = rst_n && found && can_issue;
  assign nxt_ptr   = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[g] = 1'b1;
  end

  assign add_a   = req_a[g*WIDTH +: WIDTH];
  assign add_b   = req_b[g*WIDTH +: WIDTH];
  assign add_cin = (state == LOCKED) ? carry_q : req_cin[g];

  cla_16bits u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // In LOCKED g equals owner, so nxt_ptr already yields owner+1 on chain release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= '0;
      owner     <= '0;
      carry_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_id    <= g;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
      if (req_chain[g]) begin
        state   <= LOCKED;
        owner   <= g;
        carry_q <= add_cout;
      end else begin
        state   <= ARB;
        ptr     <= nxt_ptr;
        carry_q <= 1'b0;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule
